// File: rtl/vga_timing_gen.sv
// Programmable VGA/DVI timing generator: timing outputs are registered once, then delayed PIPE more cycles.
// No backpressure; enable=0 freezes counters and pipeline, and cfg_load is still accepted.
module vga_timing_gen #(
  parameter int CW     = 11,
  parameter int PIPE   = 0,
  parameter int D_HACT = 640,
  parameter int D_HFP  = 16,
  parameter int D_HS   = 96,
  parameter int D_HBP  = 48,
  parameter int D_VACT = 480,
  parameter int D_VFP  = 10,
  parameter int D_VS   = 2,
  parameter int D_VBP  = 33,
  parameter bit D_HPOL = 1'b0,
  parameter bit D_VPOL = 1'b0
) (
  input  logic          pixel_clock,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [CW-1:0] cfg_h_act,
  input  logic [CW-1:0] cfg_h_fp,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_bp,
  input  logic [CW-1:0] cfg_v_act,
  input  logic [CW-1:0] cfg_v_fp,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_bp,
  input  logic          cfg_h_pol,
  input  logic          cfg_v_pol,
  input  logic          cfg_load,
  output logic          cfg_pending,
  output logic          cfg_err,
  output logic          h_sync,
  output logic          v_sync,
  output logic          disp_enable,
  output logic [CW-1:0] column,
  output logic [CW-1:0] row,
  output logic          line_start,
  output logic          frame_start
);

  localparam int XW = CW + 2;

  typedef struct packed {
    logic [CW-1:0] act;
    logic [CW-1:0] fp;
    logic [CW-1:0] sync;
    logic [CW-1:0] bp;
  } axis_t;

  typedef struct packed {
    axis_t h;
    axis_t v;
    logic  h_pol;
    logic  v_pol;
  } mode_t;

  typedef struct packed {
    logic          h_sync;
    logic          v_sync;
    logic          disp_enable;
    logic          line_start;
    logic          frame_start;
    logic [CW-1:0] column;
    logic [CW-1:0] row;
  } tim_t;

  localparam mode_t MODE_DEF = mode_t'({CW'(D_HACT), CW'(D_HFP), CW'(D_HS), CW'(D_HBP),
                                        CW'(D_VACT), CW'(D_VFP), CW'(D_VS), CW'(D_VBP),
                                        D_HPOL, D_VPOL});
  localparam tim_t TIM_RST = tim_t'({~D_HPOL, ~D_VPOL, 3'b000, {(2*CW){1'b0}}});
  localparam logic [XW-1:0] MAX_TOTAL = {2'b01, {CW{1'b0}}};

  function automatic logic [XW-1:0] ext(input logic [CW-1:0] x);
    return {2'b00, x};
  endfunction

  function automatic logic [XW-1:0] total(input axis_t a);
    return ext(a.act) + ext(a.fp) + ext(a.sync) + ext(a.bp);
  endfunction

  // Widened sums keep every accepted mode free of wrap-around in the bounds.
  function automatic logic axis_bad(input axis_t a);
    return (a.act == '0) || (a.sync == '0) || (total(a) > MAX_TOTAL);
  endfunction

  mode_t         act_q, pend_q, cfg_in;
  logic [CW-1:0] h_q, v_q;
  logic          h_last, v_last, wrap, cfg_ok;
  logic          in_h_act, in_v_act, in_hs, in_vs;
  tim_t          tim_d;
  tim_t          pipe_q [PIPE+1];

  assign cfg_in = {cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp,
                   cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp,
                   cfg_h_pol, cfg_v_pol};
  assign cfg_ok = !(axis_bad(cfg_in.h) || axis_bad(cfg_in.v));

  assign h_last = ext(h_q) == total(act_q.h) - XW'(1);
  assign v_last = ext(v_q) == total(act_q.v) - XW'(1);
  assign wrap   = enable && h_last && v_last;

  assign in_h_act = h_q < act_q.h.act;
  assign in_v_act = v_q < act_q.v.act;
  assign in_hs    = (ext(h_q) >= ext(act_q.h.act) + ext(act_q.h.fp)) &&
                    (ext(h_q) <  ext(act_q.h.act) + ext(act_q.h.fp) + ext(act_q.h.sync));
  assign in_vs    = (ext(v_q) >= ext(act_q.v.act) + ext(act_q.v.fp)) &&
                    (ext(v_q) <  ext(act_q.v.act) + ext(act_q.v.fp) + ext(act_q.v.sync));

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      h_q         <= '0;
      v_q         <= '0;
      act_q       <= MODE_DEF;
      pend_q      <= MODE_DEF;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= cfg_load && !cfg_ok;
      if (enable) begin
        if (h_last) begin
          h_q <= '0;
          v_q <= v_last ? '0 : v_q + CW'(1);
        end else begin
          h_q <= h_q + CW'(1);
        end
      end
      // The pending shadow is read before a same-edge load overwrites it.
      if (wrap && cfg_pending)
        act_q <= pend_q;
      if (cfg_load && cfg_ok) begin
        pend_q      <= cfg_in;
        cfg_pending <= 1'b1;
      end else if (wrap) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    tim_d             = TIM_RST;
    tim_d.h_sync      = in_hs ? act_q.h_pol : ~act_q.h_pol;
    tim_d.v_sync      = in_vs ? act_q.v_pol : ~act_q.v_pol;
    tim_d.disp_enable = in_h_act && in_v_act;
    tim_d.line_start  = (h_q == '0);
    tim_d.frame_start = (h_q == '0) && (v_q == '0);
    tim_d.column      = (in_h_act && in_v_act) ? h_q : '0;
    tim_d.row         = (in_h_act && in_v_act) ? v_q : '0;
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= PIPE; i++)
        pipe_q[i] <= TIM_RST;
    end else if (enable) begin
      pipe_q[0] <= tim_d;
      for (int i = 1; i <= PIPE; i++)
        pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign h_sync      = pipe_q[PIPE].h_sync;
  assign v_sync      = pipe_q[PIPE].v_sync;
  assign disp_enable = pipe_q[PIPE].disp_enable;
  assign line_start  = pipe_q[PIPE].line_start;
  assign frame_start = pipe_q[PIPE].frame_start;
  assign column      = pipe_q[PIPE].column;
  assign row         = pipe_q[PIPE].row;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised, runtime-reconfigurable VGA/DVI timing generator. It is the successor to the fixed-mode VGA controller.
- Generates h_sync, v_sync, disp_enable, row/column coordinates and frame/line strobes.
- Horizontal and vertical timing and sync polarity are programmed through a shadowed config interface that takes effect only at frame boundaries.
- Outputs have a parameterised alignment delay so downstream pixel pipelines line up with sync.

Parameters:
CW, 11, counter/coordinate width in bits; all cfg fields are CW bits.
PIPE, 0, extra output delay stages, 0..4, applied equally to every timing output.
D_HACT/D_HFP/D_HS/D_HBP, 640/16/96/48, reset-default horizontal timing.
D_VACT/D_VFP/D_VS/D_VBP, 480/10/2/33, reset-default vertical timing.
D_HPOL/D_VPOL, 0/0, reset-default sync polarity (0 = active-low sync).

Ports:
pixel_clock  in  1  pixel clock; all logic on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
enable  in  1  1 = counters run; 0 = freeze.
cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  CW each  requested horizontal timing.
cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  CW each  requested vertical timing.
cfg_h_pol, cfg_v_pol  in  1 each  requested sync polarity.
cfg_load  in  1  single-cycle strobe that captures all cfg_* into the pending shadow.
cfg_pending  out  1  high while a captured config awaits its frame boundary.
cfg_err  out  1  one-cycle pulse when cfg_load is rejected.
h_sync, v_sync  out  1 each  sync outputs at the programmed polarity.
disp_enable  out  1  high in the active area.
column, row  out  CW each  active-area coordinates; 0 outside the active area.
line_start  out  1  one-cycle pulse at h=0 of every line.
frame_start  out  1  one-cycle pulse at h=0, v=0.

Behaviour:
- Counters: h counts 0..HT-1, where HT = act+fp+sync+bp. At h=HT-1, h wraps to 0 and v increments. v counts 0..VT-1 and wraps to 0 on the edge where h wraps with v=VT-1.
- Regions, from current counters:
  - active when h<HACT and v<VACT;
  - h sync asserted when HACT+HFP <= h < HACT+HFP+HS;
  - v sync likewise on v.
- Timing outputs are registered from counter state (1 cycle), then pass through PIPE extra flop stages.
  - column=h and row=v when active, else 0.
  - Sync output = pol when in region, else ~pol.
- enable=0: counters, the pipeline and all outputs hold their values. Config capture still works.
- Config capture, on a cfg_load edge:
  - Reject if any of h_act, v_act, h_sync, v_sync is 0, or if any total (computed at CW+2 bits) exceeds 2^CW.
  - Rejected: cfg_err=1 for one cycle; pending shadow unchanged.
  - Accepted: pending <= cfg_*; cfg_pending=1.
- Apply, on the wrap edge to (0,0) with cfg_pending=1: active timing <= pending; cfg_pending cleared.
  - The first frame after apply uses the new timing.
- Simultaneous apply and accepted cfg_load on the same edge: the old pending value is applied, the new value is captured, and cfg_pending stays 1. It applies at the next frame boundary.
- Reset (reset_n low, asynchronous):
  - h=v=0; active timing and pending shadow = D_* defaults; cfg_pending=0; cfg_err=0.
  - All pipeline stages flush to: disp_enable=0, row=column=0, line_start=frame_start=0, h_sync=~D_HPOL, v_sync=~D_VPOL.
- First cycle after reset release (enable=1, PIPE=0): outputs reflect h=0, v=0 on the next edge, i.e. disp_enable=1, frame_start=1, line_start=1.
- Reset mid-frame discards the pending config.
- All counter arithmetic is unsigned CW-bit. Region bounds are computed at CW+2 bits, so no overflow is possible with accepted configs.

Test Plan:
- Reset defaults, PIPE=0: after release, count 800 cycles per line and 525 lines per frame. h_sync low for cycles 656..751 of each line; v_sync low on lines 490..491; disp_enable high for 640 cycles on lines 0..479.
- Small mode: load h 8/2/3/3 and v 4/1/1/2 mid-frame. cfg_pending=1 until the default frame ends. Next frame: line = 16 cycles, frame = 8 lines, h_sync on h=10..12, frame_start every 128 cycles.
- Polarity: load cfg_h_pol=1, cfg_v_pol=1 with the small mode. After apply, h_sync idles 0 and pulses 1 for 3 cycles; v_sync pulses 1 for 16 cycles.
- Rejects: cfg_load with cfg_h_act=0, then with h total 2100 (CW=11). cfg_err pulses each time; cfg_pending stays 0; timing unchanged.
- Boundary load and enable: assert cfg_load exactly on the wrap edge. The previous pending applies, the new one applies one frame later, and cfg_pending stays high across the edge. Drop enable for 5 cycles mid-line: all outputs frozen, line length extends by exactly 5.
- PIPE=3 and async reset: with PIPE=3, every output is shifted by exactly 3 cycles versus PIPE=0 under the same stimulus. Assert reset_n low mid-line: outputs go to reset values immediately (no clock edge).
